// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Overflow reporting is built only when SERIAL_SUB_OVF_EN is defined.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  // uio_in bit positions
  localparam int LOAD_A = 0;
  localparam int LOAD_B = 1;
  localparam int START  = 2;

  // uio_out bit positions
  localparam int BUSY   = 4;
  localparam int DONE   = 5;
  localparam int BORROW = 6;
  localparam int OVF    = 7;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor; two of these plus an OR form a full-subtract slice.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/tt_um_taghreed_eialsalman_serial_subtractor.sv
// Bit-serial A-B subtractor, one bit per clock, LSB first.
// Optional: SERIAL_SUB_OVF_EN adds signed-overflow reporting on uio_out[7].
module tt_um_taghreed_eialsalman_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import serial_sub_pkg::*;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d, out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               borrow_out_q, borrow_out_d;
  logic               done_q, done_d;
  logic               start_q, start_d;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic start_evt, load_a, load_b;
  logic d1, bo1, bo2, diff_bit, borrow_next;

  assign load_a    = uio_in[LOAD_A];
  assign load_b    = uio_in[LOAD_B];
  assign start_evt = uio_in[START] & ~start_q;

  half_subtractor u_hs_ab (.a(a_q[0]), .b(b_q[0]),   .diff(d1),       .bout(bo1));
  half_subtractor u_hs_br (.a(d1),     .b(borrow_q), .diff(diff_bit), .bout(bo2));
  assign borrow_next = bo1 | bo2;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    done_d       = done_q;
    start_d      = start_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d        = ovf_q;
`endif
    if (ena) begin
      start_d = uio_in[START];
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_evt) begin
            state_d  = ST_SHIFT;
            borrow_d = 1'b0;
            cnt_d    = '0;
            done_d   = 1'b0;
          end else if (load_a || load_b) begin
            if (load_a) a_d = ui_in[WIDTH-1:0];
            if (load_b) b_d = ui_in[WIDTH-1:0];
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end
        end
        ST_SHIFT: begin
          // Operands rotate rather than zero-fill so they are intact after the run.
          a_d      = {a_q[0], a_q[WIDTH-1:1]};
          b_d      = {b_q[0], b_q[WIDTH-1:1]};
          res_d    = {diff_bit, res_q[WIDTH-1:1]};
          borrow_d = borrow_next;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d      = ST_DONE;
            done_d       = 1'b1;
            out_d        = res_d;
            borrow_out_d = borrow_next;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the slice inputs are the operand sign bits.
            ovf_d = (a_q[0] ^ b_q[0]) & (diff_bit ^ a_q[0]);
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      out_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
      start_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      done_q       <= done_d;
      start_q      <= start_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  always_comb begin
    uio_out         = '0;
    uio_out[BUSY]   = (state_q == ST_SHIFT);
    uio_out[DONE]   = done_q;
    uio_out[BORROW] = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    uio_out[OVF]    = ovf_q;
`else
    uio_out[OVF]    = 1'b0;
`endif
  end

  assign uo_out = out_q;
  assign uio_oe = 8'hF0;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_serial_subtractor.sv
// Directed bench for the serial subtractor; expected values are hand-computed.
module tb_tt_um_taghreed_eialsalman_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_taghreed_eialsalman_serial_subtractor #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_80_01 = 1'b1;
`else
  localparam logic OVF_80_01 = 1'b0;
`endif

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); ui_in = a; uio_in = 8'h01;
    @(negedge clk); ui_in = b; uio_in = 8'h02;
    @(negedge clk); uio_in = 8'h00;
  endtask

  // Raise start and wait for done; optional held start, ena freeze, load during busy.
  task automatic start_wait(input bit hold, input int ena_off, input int load_at,
                            output int cyc, output int busy_n, output bit to);
    @(negedge clk); uio_in = 8'h04;
    cyc = 0; busy_n = 0; to = 1'b1;
    while (cyc < 40) begin
      @(negedge clk); cyc++;
      if (uio_out[4]) busy_n++;
      if (uio_out[5]) begin to = 1'b0; break; end
      uio_in = hold ? 8'h04 : 8'h00;
      if (cyc == load_at) begin uio_in = uio_in | 8'h01; ui_in = 8'hFF; end
      if (ena_off != 0 && cyc == ena_off) ena = 1'b0;
      if (ena_off != 0 && cyc == ena_off + 5) ena = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL uio_oe got %h want f0", uio_oe); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc, bn; bit to;
    load_ab(8'h35, 8'h12);
    start_wait(1'b0, 0, 0, cyc, bn, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (cyc != 9) begin errors++; $display("FAIL basic_latency got %0d want 9", cyc); end
    checks++; if (bn != 8) begin errors++; $display("FAIL basic_busy got %0d want 8", bn); end
    checks++; if (uo_out !== 8'h23) begin errors++; $display("FAIL basic_result got %h want 23", uo_out); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL basic_flags got %h want 20", uio_out); end
  endtask

  task automatic test_borrow;
    int cyc, bn; bit to;
    load_ab(8'h12, 8'h35);
    start_wait(1'b0, 0, 0, cyc, bn, to);
    checks++; if (to || uo_out !== 8'hDD) begin errors++; $display("FAIL borrow1_result got %h want dd", uo_out); end
    checks++; if (uio_out[6] !== 1'b1) begin errors++; $display("FAIL borrow1_flag got %b want 1", uio_out[6]); end
    checks++; if (uio_out[7] !== 1'b0) begin errors++; $display("FAIL borrow1_ovf got %b want 0", uio_out[7]); end
    load_ab(8'h00, 8'h01);
    start_wait(1'b0, 0, 0, cyc, bn, to);
    checks++; if (to || uo_out !== 8'hFF) begin errors++; $display("FAIL borrow2_result got %h want ff", uo_out); end
    checks++; if (uio_out[6] !== 1'b1) begin errors++; $display("FAIL borrow2_flag got %b want 1", uio_out[6]); end
  endtask

  task automatic test_ovf;
    int cyc, bn; bit to;
    load_ab(8'h80, 8'h01);
    start_wait(1'b0, 0, 0, cyc, bn, to);
    checks++; if (to || uo_out !== 8'h7F) begin errors++; $display("FAIL ovf1_result got %h want 7f", uo_out); end
    checks++; if (uio_out[7] !== OVF_80_01) begin errors++; $display("FAIL ovf1_flag got %b want %b", uio_out[7], OVF_80_01); end
    checks++; if (uio_out[6] !== 1'b0) begin errors++; $display("FAIL ovf1_borrow got %b want 0", uio_out[6]); end
    load_ab(8'h7F, 8'h01);
    start_wait(1'b0, 0, 0, cyc, bn, to);
    checks++; if (to || uo_out !== 8'h7E) begin errors++; $display("FAIL ovf2_result got %h want 7e", uo_out); end
    checks++; if (uio_out[7] !== 1'b0) begin errors++; $display("FAIL ovf2_flag got %b want 0", uio_out[7]); end
  endtask

  task automatic test_load_clears_done;
    @(negedge clk); ui_in = 8'h10; uio_in = 8'h01;
    @(negedge clk); uio_in = 8'h00;
    checks++; if (uio_out[5] !== 1'b0) begin errors++; $display("FAIL load_done got %b want 0", uio_out[5]); end
    checks++; if (uo_out !== 8'h7E) begin errors++; $display("FAIL load_keep got %h want 7e", uo_out); end
  endtask

  task automatic test_held_start;
    int cyc, bn; bit to;
    load_ab(8'h35, 8'h12);
    start_wait(1'b1, 0, 0, cyc, bn, to);
    repeat (21) begin
      @(negedge clk);
      if (uio_out[4]) bn++;
    end
    checks++; if (to || bn != 8) begin errors++; $display("FAIL held_busy got %0d want 8", bn); end
    checks++; if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL held_done got %b want 1", uio_out[5]); end
    checks++; if (uo_out !== 8'h23) begin errors++; $display("FAIL held_result got %h want 23", uo_out); end
    uio_in = 8'h00;
  endtask

  task automatic test_load_during_busy;
    int cyc, bn; bit to;
    start_wait(1'b0, 0, 3, cyc, bn, to);
    checks++; if (to || uo_out !== 8'h23) begin errors++; $display("FAIL busyload_result got %h want 23", uo_out); end
    start_wait(1'b0, 0, 0, cyc, bn, to);
    checks++; if (to || uo_out !== 8'h23) begin errors++; $display("FAIL busyload_a_kept got %h want 23", uo_out); end
  endtask

  task automatic test_reset_mid_shift;
    int cyc, bn; bit to;
    load_ab(8'h12, 8'h35);
    start_wait(1'b0, 0, 0, cyc, bn, to);
    @(negedge clk); uio_in = 8'h04;
    repeat (4) @(negedge clk);
    uio_in = 8'h00;
    checks++; if (uio_out[4] !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", uio_out[4]); end
    rst_n = 1'b0;
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL midrst_uo got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL midrst_uio got %h want 00", uio_out); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL midrst_idle got %h want 00", uio_out); end
    load_ab(8'h35, 8'h12);
    start_wait(1'b0, 0, 0, cyc, bn, to);
    checks++; if (to || uo_out !== 8'h23) begin errors++; $display("FAIL midrst_next got %h want 23", uo_out); end
  endtask

  task automatic test_ena_freeze;
    int cyc, bn; bit to;
    load_ab(8'h12, 8'h35);
    start_wait(1'b0, 3, 0, cyc, bn, to);
    checks++; if (to || cyc != 14) begin errors++; $display("FAIL ena_latency got %0d want 14", cyc); end
    checks++; if (bn != 13) begin errors++; $display("FAIL ena_busy got %0d want 13", bn); end
    checks++; if (uo_out !== 8'hDD) begin errors++; $display("FAIL ena_result got %h want dd", uo_out); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_ovf;
    test_load_clears_done;
    test_held_start;
    test_load_during_busy;
    test_reset_mid_shift;
    test_ena_freeze;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_taghreed_eialsalman_serial_subtractor.md
TT_UM_TAGHREED_EIALSALMAN_SERIAL_SUBTRACTOR -- requirements
Module: tt_um_taghreed_eialsalman_serial_subtractor

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ena, input, 1 bit: design enable; when low, all registers hold their value.
REQ-004 SHALL have port ui_in, input, 8 bits: operand byte to be loaded.
REQ-005 SHALL have port uio_in, input, 8 bits: [0] load_a, [1] load_b, [2] start; [7:3] unused.
REQ-006 SHALL have port uo_out, output, 8 bits: difference register A-B (mod 256).
REQ-007 SHALL have port uio_out, output, 8 bits: [4] busy, [5] done, [6] borrow, [7] ovf; [3:0] tied to 0.
REQ-008 SHALL drive uio_oe to constant 8'hF0.
REQ-009 SHALL have parameter WIDTH, default 8: operand width; only the value 8 is supported at the top level.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 SHALL, in IDLE or DONE, capture ui_in into the A register when load_a=1, and into the B register when load_b=1; both loads may occur in the same cycle.
REQ-012 SHALL form a start event as the rising edge of start (start & ~start_q); a held-high start yields exactly one operation.
REQ-013 SHALL, on a start event in IDLE or DONE, enter SHIFT, clear the borrow FF, clear the bit counter and clear done; any load in the same cycle is ignored.
REQ-014 SHALL, in SHIFT, process one bit per cycle, LSB first: diff_bit = a0^b0^borrow, borrow_next = (~a0&b0) | (~(a0^b0)&borrow); then shift A and B right and shift diff_bit into the MSB of the result shift register.
REQ-015 SHALL leave SHIFT after exactly 8 bit-cycles; uo_out, borrow and ovf SHALL update on the transition to DONE.
REQ-016 SHALL hold done=1 in DONE until the next start event or load; a load SHALL return the FSM to IDLE with done=0 while uo_out keeps its last result.
REQ-017 SHALL ignore load_a, load_b and start events while busy (SHIFT).
REQ-018 SHALL assert busy=1 exactly in SHIFT; latency from start-edge cycle to done=1 is 9 clocks.
REQ-019 SHALL freeze FSM, counter and start_q while ena=0, so that no edge is lost or invented.
REQ-020 SHALL report borrow=1 iff A<B (unsigned), i.e. the final borrow FF value.

Reset
REQ-021 SHALL, while rst_n=0, force IDLE, A=B=0, result=0, borrow=0, ovf=0, counter=0, start_q=0; uo_out=0 and uio_out=0.
REQ-022 SHALL, on reset asserted mid-SHIFT, abort the operation without updating outputs and restart in IDLE.

Configuration
REQ-023 SHALL use macro SERIAL_SUB_OVF_EN: when defined, ovf = two's-complement overflow of A-B (sign(A)!=sign(B) and sign(result)!=sign(A)), latched at DONE; when undefined, uio_out[7] is constant 0 and no overflow logic exists.

Structure
REQ-024 SHALL place in package serial_sub_pkg: the FSM state enum, WIDTH, the counter width, and the uio bit-index constants (LOAD_A, LOAD_B, START, BUSY, DONE, BORROW, OVF).
REQ-025 SHALL build the bit slice from sub-module half_subtractor (diff=a^b, bout=~a&b), instantiated twice with the two borrows ORed.
REQ-026 SHALL consume all unused inputs into a single unused-reduction wire.

Verification
REQ-027 SHALL cover: A=0x35, B=0x12, start -> after 9 clks uo_out=0x23, borrow=0, done=1.
REQ-028 SHALL cover: A=0x12, B=0x35 -> uo_out=0xDD, borrow=1; A=0x00, B=0x01 -> uo_out=0xFF, borrow=1.
REQ-029 SHALL cover: with SERIAL_SUB_OVF_EN, A=0x80, B=0x01 -> uo_out=0x7F, ovf=1; A=0x7F, B=0x01 -> ovf=0; without the macro, uio_out[7]=0.
REQ-030 SHALL cover: start held high 30 clks -> exactly one busy window of 8 clks; a load_a pulse during busy leaves A unchanged.
REQ-031 SHALL cover: rst_n low at bit-cycle 4 -> all outputs 0, IDLE; the next operation 0x35-0x12 yields 0x23.
REQ-032 SHALL cover: ena=0 for 5 clks mid-SHIFT -> result unchanged, done delayed by 5 clks.
